regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources.
- Source A is the in-order pipeline writeback: ALU results and loads.
- Source B is a multi-cycle unit (multiplier/divider) that completes out of band.
- B results are buffered in a small FIFO. A fixed A-first priority with an anti-starvation counter picks one write per cycle. The block drives regWrite/writeAddr/regWriteData into the register file.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_wb_fifo.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and the writeback entry type for the register-file
// writeback arbiter.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    // Writes to this register are consumed but never reach the register file.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Synchronous FIFO holding buffered multi-cycle-unit writebacks.
// The storage array is not reset; only pointers and count are.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the in-order pipeline (A)
// and a buffered multi-cycle unit (B): A-first with a B anti-starvation limit.
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int ADDR_W       = regfile_pkg::ADDR_W,
    parameter int DATA_W       = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [DATA_W-1:0] regWriteData,
    output logic              b_pending,
    output logic              stall_a
);

    localparam int EW = ADDR_W + DATA_W;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [EW-1:0]     head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [SW-1:0]     starve_cnt;
    logic              force_b;
    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (b_valid && b_ready),
        .pop   (grant_b),
        .wdata ({b_addr, b_data}),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign {head_addr, head_data} = head;

    // b_ready comes straight from the registered count, so a same-cycle pop
    // never opens room for a push into a full FIFO.
    assign b_ready   = (fifo_count != CW'(FIFO_DEPTH));
    assign b_pending = !fifo_empty;

    assign force_b = (starve_cnt == SW'(STARVE_LIMIT));
    assign grant_b = b_pending && (force_b || !a_valid);
    assign grant_a = a_valid && !grant_b;
    assign a_ready = grant_a;
    assign stall_a = a_valid && !grant_a;

    always_comb begin
        sel_addr = a_addr;
        sel_data = a_data;
        if (grant_b) begin
            sel_addr = head_addr;
            sel_data = head_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (fifo_empty || grant_b) begin
            starve_cnt <= '0;
        end else if (!force_b) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Output register: one write per grant, address/data hold while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWrite     <= 1'b0;
            writeAddr    <= '0;
            regWriteData <= '0;
        end else if (grant_a || grant_b) begin
            regWrite     <= (sel_addr != ADDR_W'(regfile_pkg::REG_ZERO));
            writeAddr    <= sel_addr;
            regWriteData <= sel_data;
        end else begin
            regWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-cycle vector table with
// hand-derived grants, a write scoreboard, and an async-reset sequence.
module tb_regfile_wb_arbiter;

    import regfile_pkg::*;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_A    = 2'd1;
    localparam logic [1:0] G_B    = 2'd2;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        e_ard;
        logic        e_stall;
        logic        e_brdy;
        logic        e_bpend;
        logic [1:0]  e_gnt;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        regWrite;
    logic [4:0]  writeAddr;
    logic [31:0] regWriteData;
    logic        b_pending;
    logic        stall_a;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t      vq[$];
    wb_entry_t bq[$];
    wb_entry_t wq[$];
    wb_entry_t last;

    regfile_wb_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (3),
        .ADDR_W       (5),
        .DATA_W       (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .regWrite     (regWrite),
        .writeAddr    (writeAddr),
        .regWriteData (regWriteData),
        .b_pending    (b_pending),
        .stall_a      (stall_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic ard, input logic stl, input logic brdy,
                       input logic bpend, input logic [1:0] gnt);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv; v.ba = ba; v.bd = bd;
        v.e_ard = ard; v.e_stall = stl; v.e_brdy = brdy;
        v.e_bpend = bpend; v.e_gnt = gnt;
        vq.push_back(v);
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input int idx, input vec_t v);
        wb_entry_t e;
        string     tag;
        tag = $sformatf("v%0d", idx);
        a_valid = v.av; a_addr = v.aa; a_data = v.ad;
        b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
        #3;
        chk({tag, "_a_ready"},   64'(a_ready),   64'(v.e_ard));
        chk({tag, "_stall_a"},   64'(stall_a),   64'(v.e_stall));
        chk({tag, "_b_ready"},   64'(b_ready),   64'(v.e_brdy));
        chk({tag, "_b_pending"}, 64'(b_pending), 64'(v.e_bpend));
        if (v.e_gnt == G_A) begin
            e.addr = v.aa; e.data = v.ad;
            wq.push_back(e);
        end else if (v.e_gnt == G_B) begin
            if (bq.size() == 0) begin
                chk({tag, "_bq_nonempty"}, 64'(0), 64'(1));
            end else begin
                wq.push_back(bq.pop_front());
            end
        end
        if (v.bv && v.e_brdy) begin
            e.addr = v.ba; e.data = v.bd;
            bq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (wq.size() != 0) begin
            e = wq.pop_front();
            chk({tag, "_regWrite"},     64'(regWrite),     64'(e.addr != 5'd0));
            chk({tag, "_writeAddr"},    64'(writeAddr),    64'(e.addr));
            chk({tag, "_regWriteData"}, 64'(regWriteData), 64'(e.data));
            last = e;
        end else begin
            chk({tag, "_regWrite_idle"}, 64'(regWrite),     64'(0));
            chk({tag, "_addr_hold"},     64'(writeAddr),    64'(last.addr));
            chk({tag, "_data_hold"},     64'(regWriteData), 64'(last.data));
        end
    endtask

    initial begin
        int n_pre;
        reset = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        last = '0;

        // Basic A write, then idle hold.
        add(0, 0, 0,            0, 0, 0,      0, 0, 1, 0, G_NONE);
        add(1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 0, 1, 0, G_A);
        add(0, 0, 0,            0, 0, 0,      0, 0, 1, 0, G_NONE);
        // Address-0 writes from both sources are consumed silently.
        add(1, 0, 32'h1234,     0, 0, 0,      1, 0, 1, 0, G_A);
        add(0, 0, 0,            1, 0, 32'h55, 0, 0, 1, 0, G_NONE);
        add(0, 0, 0,            0, 0, 0,      0, 0, 1, 1, G_B);
        add(0, 0, 0,            0, 0, 0,      0, 0, 1, 0, G_NONE);
        // Starvation: A wins three cycles, then B is forced through.
        add(0, 0, 0,            1, 7, 32'h77, 0, 0, 1, 0, G_NONE);
        add(1, 1, 32'h1,        0, 0, 0,      1, 0, 1, 1, G_A);
        add(1, 2, 32'h2,        0, 0, 0,      1, 0, 1, 1, G_A);
        add(1, 3, 32'h3,        0, 0, 0,      1, 0, 1, 1, G_A);
        add(1, 4, 32'h4,        0, 0, 0,      0, 1, 1, 1, G_B);
        add(1, 4, 32'h4,        0, 0, 0,      1, 0, 1, 0, G_A);
        add(1, 5, 32'h5,        0, 0, 0,      1, 0, 1, 0, G_A);
        // Fill the FIFO while A is busy; fifth push is refused.
        add(1, 6,  32'h6,       1, 8,  32'h88, 1, 0, 1, 0, G_A);
        add(1, 9,  32'h9,       1, 10, 32'hA0, 1, 0, 1, 1, G_A);
        add(1, 11, 32'hB,       1, 12, 32'hC0, 1, 0, 1, 1, G_A);
        add(1, 13, 32'hD,       1, 14, 32'hE0, 1, 0, 1, 1, G_A);
        add(1, 15, 32'hF,       1, 16, 32'hF0, 0, 1, 0, 1, G_B);
        add(1, 15, 32'hF,       0, 0,  0,      1, 0, 1, 1, G_A);
        add(1, 17, 32'h11,      0, 0,  0,      1, 0, 1, 1, G_A);
        add(1, 18, 32'h12,      0, 0,  0,      1, 0, 1, 1, G_A);
        add(1, 19, 32'h13,      0, 0,  0,      0, 1, 1, 1, G_B);
        add(0, 0,  0,           0, 0,  0,      0, 0, 1, 1, G_B);
        add(0, 0,  0,           0, 0,  0,      0, 0, 1, 1, G_B);
        add(0, 0,  0,           0, 0,  0,      0, 0, 1, 0, G_NONE);
        // Same destination from both sides: grant order decides.
        add(0, 0,  0,           1, 3,  32'h33, 0, 0, 1, 0, G_NONE);
        add(1, 3,  32'h31,      0, 0,  0,      1, 0, 1, 1, G_A);
        add(0, 0,  0,           0, 0,  0,      0, 0, 1, 1, G_B);
        // Load three B entries ahead of the asynchronous reset.
        add(1, 20, 32'h200,     1, 21, 32'h210, 1, 0, 1, 0, G_A);
        add(1, 22, 32'h220,     1, 23, 32'h230, 1, 0, 1, 1, G_A);
        add(1, 24, 32'h240,     1, 25, 32'h250, 1, 0, 1, 1, G_A);
        n_pre = vq.size();
        // After reset release nothing stale may appear.
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, G_NONE);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, G_NONE);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, G_NONE);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_regWrite",     64'(regWrite),     64'(0));
        chk("rst_writeAddr",    64'(writeAddr),    64'(0));
        chk("rst_regWriteData", 64'(regWriteData), 64'(0));
        reset = 1'b1;
        #1;
        chk("rel_b_ready",   64'(b_ready),   64'(1));
        chk("rel_b_pending", 64'(b_pending), 64'(0));
        @(posedge clk);
        #1;

        for (int i = 0; i < n_pre; i++) step(i, vq[i]);

        chk("pre_rst_b_pending", 64'(b_pending), 64'(1));
        chk("pre_rst_regWrite",  64'(regWrite),  64'(1));
        a_valid = 1'b0; b_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_regWrite",     64'(regWrite),     64'(0));
        chk("async_b_pending",    64'(b_pending),    64'(0));
        chk("async_writeAddr",    64'(writeAddr),    64'(0));
        chk("async_regWriteData", 64'(regWriteData), 64'(0));
        bq.delete();
        wq.delete();
        last = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = n_pre; i < vq.size(); i++) step(i, vq[i]);

        chk("end_bq_drained", 64'(bq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
